frame_ring_manager: RTL and testbench

- N-way generalisation of the double-buffer swap logic between the ray marcher (producer) and the VGA display (consumer).
- Tracks ownership of NUM_BUFS frame-buffer slots in one physical BRAM address space and hands the producer a free slot on every finished frame.
- Hands the display the newest completed frame at each display frame boundary.
- Supports triple buffering (no producer stall), counts dropped frames, and keeps the NUM_BUFS=2 stall mode.

---
 rtl/frame_ring_manager_pkg.sv | 25 ++
 rtl/frame_ring_manager_if.sv | 35 +++
 rtl/frame_ring_manager_slot_picker.sv | 22 ++
 rtl/frame_ring_manager.sv | 135 +++++++++++++
 tb/tb_frame_ring_manager.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_ring_manager_pkg.sv
// Shared types for the frame ring manager: slot ownership states and the
// physical BRAM sizing helpers used by the top level and the bus interface.
`ifndef FRAME_RING_MANAGER_PKG_SV
`define FRAME_RING_MANAGER_PKG_SV

// Physical address width for a ring of nb slots of 2**ab pixels each.
`define FRM_BUF_ADDR_BITS(nb, ab) ($clog2(nb) + (ab))

package frame_ring_manager_pkg;

  // Default per-slot pixel address width; the shared BRAM holds
  // NUM_BUFS * FRM_BRAM_SIZE pixels.
  localparam int FRM_ADDR_BITS = 17;
  localparam int FRM_BRAM_SIZE = 1 << FRM_ADDR_BITS;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_WRITING = 2'd1,
    SLOT_READY   = 2'd2,
    SLOT_DISPLAY = 2'd3
  } slot_state_e;

endpackage

`endif

// File: rtl/frame_ring_manager_if.sv
// Producer/display side bus of the frame ring manager. The master modport is
// the producer+display environment, the slave modport is the manager itself.
interface frame_ring_if #(
  parameter int NUM_BUFS  = 3,
  parameter int ADDR_BITS = 17,
  parameter int CNT_BITS  = 16
);
  localparam int BUF_BITS  = $clog2(NUM_BUFS);
  localparam int PHYS_BITS = `FRM_BUF_ADDR_BITS(NUM_BUFS, ADDR_BITS);

  logic                 frame_done_in;
  logic                 vsync_in;
  logic [ADDR_BITS-1:0] wr_addr_in;
  logic [ADDR_BITS-1:0] rd_addr_in;
  logic [PHYS_BITS-1:0] wr_addr_out;
  logic [PHYS_BITS-1:0] rd_addr_out;
  logic [BUF_BITS-1:0]  write_sel_out;
  logic [BUF_BITS-1:0]  read_sel_out;
  logic                 stall_out;
  logic                 ready_valid_out;
  logic [CNT_BITS-1:0]  drop_count_out;
  logic                 err_out;

  modport master (
    output frame_done_in, vsync_in, wr_addr_in, rd_addr_in,
    input  wr_addr_out, rd_addr_out, write_sel_out, read_sel_out,
           stall_out, ready_valid_out, drop_count_out, err_out
  );

  modport slave (
    input  frame_done_in, vsync_in, wr_addr_in, rd_addr_in,
    output wr_addr_out, rd_addr_out, write_sel_out, read_sel_out,
           stall_out, ready_valid_out, drop_count_out, err_out
  );
endinterface

// File: rtl/frame_ring_manager_slot_picker.sv
// Lowest-index priority encoder over the free-slot mask.
module slot_picker #(
  parameter int NUM_BUFS = 3
) (
  input  logic [NUM_BUFS-1:0]         free_in,
  output logic [$clog2(NUM_BUFS)-1:0] idx_out,
  output logic                        found_out
);
  localparam int BUF_BITS = $clog2(NUM_BUFS);

  // Scan from the top down so the lowest free index wins.
  always_comb begin
    idx_out   = '0;
    found_out = 1'b0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (free_in[i]) begin
        idx_out   = BUF_BITS'(i);
        found_out = 1'b1;
      end
    end
  end
endmodule

// File: rtl/frame_ring_manager.sv
// Ownership tracker for NUM_BUFS frame slots shared by the ray marcher
// (producer) and the VGA display (consumer) in one BRAM address space.
module frame_ring_manager
  import frame_ring_manager_pkg::*;
#(
  parameter int NUM_BUFS  = 3,
  parameter int ADDR_BITS = 17,
  parameter int CNT_BITS  = 16
) (
  input logic         clk_in,
  input logic         rstn_in,
  frame_ring_if.slave bus
);
  localparam int BUF_BITS = $clog2(NUM_BUFS);

  slot_state_e         slot_q [NUM_BUFS];
  slot_state_e         slot_d [NUM_BUFS];
  logic [BUF_BITS-1:0] wsel_q, wsel_d;
  logic [BUF_BITS-1:0] rsel_q, rsel_d;
  logic [BUF_BITS-1:0] rdy_q, rdy_d;
  logic                stall_q, stall_d;
  logic                rv_q, rv_d;
  logic [CNT_BITS-1:0] drop_q, drop_d;
  logic                err_q, err_d;

  logic                take_ready;
  logic                accept_done;
  logic                drop_ready;
  logic [NUM_BUFS-1:0] free_mask;
  logic [BUF_BITS-1:0] pick_idx;
  logic                pick_found;

  // Consumer swap happens first; a done pulse only drops the old READY
  // frame when the display did not take it in the same cycle.
  assign take_ready  = bus.vsync_in && rv_q;
  assign accept_done = bus.frame_done_in && !stall_q;
  assign drop_ready  = accept_done && rv_q && !take_ready;

  // Slots that are free once the consumer swap and any drop are applied.
  always_comb begin
    for (int i = 0; i < NUM_BUFS; i++) begin
      free_mask[i] = (slot_q[i] == SLOT_FREE)
                  || (take_ready && (BUF_BITS'(i) == rsel_q))
                  || (drop_ready && (BUF_BITS'(i) == rdy_q));
    end
  end

  slot_picker #(.NUM_BUFS(NUM_BUFS)) u_picker (
    .free_in   (free_mask),
    .idx_out   (pick_idx),
    .found_out (pick_found)
  );

  // State register: slot0 shown, slot1 being drawn out of reset.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        slot_q[i] <= (i == 0) ? SLOT_DISPLAY : ((i == 1) ? SLOT_WRITING : SLOT_FREE);
      end
      wsel_q  <= BUF_BITS'(1);
      rsel_q  <= '0;
      rdy_q   <= '0;
      stall_q <= 1'b0;
      rv_q    <= 1'b0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      rdy_q   <= rdy_d;
      stall_q <= stall_d;
      rv_q    <= rv_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  // Next-state: consumer swap, then writer retires, then new writer picked.
  always_comb begin
    slot_d  = slot_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    rdy_d   = rdy_q;
    stall_d = stall_q;
    rv_d    = rv_q;
    drop_d  = drop_q;
    err_d   = err_q;

    if (bus.frame_done_in && stall_q) begin
      err_d = 1'b1;
    end

    for (int i = 0; i < NUM_BUFS; i++) begin
      if (take_ready) begin
        if (BUF_BITS'(i) == rsel_q) slot_d[i] = stall_q ? SLOT_WRITING : SLOT_FREE;
        if (BUF_BITS'(i) == rdy_q)  slot_d[i] = SLOT_DISPLAY;
      end
      if (accept_done) begin
        if (drop_ready && (BUF_BITS'(i) == rdy_q)) slot_d[i] = SLOT_FREE;
        if (BUF_BITS'(i) == wsel_q)                slot_d[i] = SLOT_READY;
        if (pick_found && (BUF_BITS'(i) == pick_idx)) slot_d[i] = SLOT_WRITING;
      end
    end

    if (take_ready) begin
      rsel_d = rdy_q;
      rv_d   = 1'b0;
      if (stall_q) begin
        wsel_d  = rsel_q;
        stall_d = 1'b0;
      end
    end

    if (accept_done) begin
      rdy_d = wsel_q;
      rv_d  = 1'b1;
      if (drop_ready && (drop_q != '1)) drop_d = drop_q + 1'b1;
      if (pick_found) wsel_d  = pick_idx;
      else            stall_d = 1'b1;
    end
  end

  // Outputs: registered flags plus slot-prefixed physical addresses.
  always_comb begin
    bus.write_sel_out   = wsel_q;
    bus.read_sel_out    = rsel_q;
    bus.stall_out       = stall_q;
    bus.ready_valid_out = rv_q;
    bus.drop_count_out  = drop_q;
    bus.err_out         = err_q;
    bus.wr_addr_out     = {wsel_q, bus.wr_addr_in};
    bus.rd_addr_out     = {rsel_q, bus.rd_addr_in};
  end
endmodule

// File: tb/tb_frame_ring_manager.sv
// Bench for frame_ring_manager: three instances (3 slots, 2 slots, 4 slots
// with a 2-bit drop counter) checked every cycle against an ownership model.
module tb_frame_ring_manager;
  import frame_ring_manager_pkg::*;

  localparam int AB = 17;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  bit fd [3];
  bit vs [3];
  int wa [3];
  int ra [3];
  bit cmp_en = 1'b0;

  int total = 0;
  int bad   = 0;

  frame_ring_if #(.NUM_BUFS(3), .ADDR_BITS(AB), .CNT_BITS(16)) if_a ();
  frame_ring_if #(.NUM_BUFS(2), .ADDR_BITS(AB), .CNT_BITS(16)) if_b ();
  frame_ring_if #(.NUM_BUFS(4), .ADDR_BITS(AB), .CNT_BITS(2))  if_c ();

  assign if_a.frame_done_in = fd[0];
  assign if_a.vsync_in      = vs[0];
  assign if_a.wr_addr_in    = AB'(wa[0]);
  assign if_a.rd_addr_in    = AB'(ra[0]);
  assign if_b.frame_done_in = fd[1];
  assign if_b.vsync_in      = vs[1];
  assign if_b.wr_addr_in    = AB'(wa[1]);
  assign if_b.rd_addr_in    = AB'(ra[1]);
  assign if_c.frame_done_in = fd[2];
  assign if_c.vsync_in      = vs[2];
  assign if_c.wr_addr_in    = AB'(wa[2]);
  assign if_c.rd_addr_in    = AB'(ra[2]);

  frame_ring_manager #(.NUM_BUFS(3), .ADDR_BITS(AB), .CNT_BITS(16)) dut_a (
    .clk_in(clk), .rstn_in(rstn), .bus(if_a));
  frame_ring_manager #(.NUM_BUFS(2), .ADDR_BITS(AB), .CNT_BITS(16)) dut_b (
    .clk_in(clk), .rstn_in(rstn), .bus(if_b));
  frame_ring_manager #(.NUM_BUFS(4), .ADDR_BITS(AB), .CNT_BITS(2)) dut_c (
    .clk_in(clk), .rstn_in(rstn), .bus(if_c));

  // Model: who shows, who draws (-1 = producer stalled), who waits (-1 = none).
  int nbv  [3] = '{3, 2, 4};
  int cmax [3] = '{65535, 65535, 3};
  int m_disp [3];
  int m_wr   [3];
  int m_rdy  [3];
  int m_wsel [3];
  int m_drop [3];
  bit m_err  [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_disp[k] = 0; m_wr[k] = 1; m_rdy[k] = -1;
      m_wsel[k] = 1; m_drop[k] = 0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    bit stalled;
    int freed;
    stalled = (m_wr[k] < 0);
    if (fd[k] && stalled) m_err[k] = 1'b1;
    if (vs[k] && m_rdy[k] >= 0) begin
      freed     = m_disp[k];
      m_disp[k] = m_rdy[k];
      m_rdy[k]  = -1;
      if (stalled) begin
        m_wr[k]   = freed;
        m_wsel[k] = freed;
      end
    end
    if (fd[k] && !stalled) begin
      if (m_rdy[k] >= 0 && m_drop[k] < cmax[k]) m_drop[k]++;
      m_rdy[k] = m_wr[k];
      m_wr[k]  = -1;
      for (int s = 0; s < nbv[k]; s++) begin
        if (m_wr[k] < 0 && s != m_disp[k] && s != m_rdy[k]) begin
          m_wr[k]   = s;
          m_wsel[k] = s;
        end
      end
    end
  endtask

  function automatic int exp_slot(input int k, input int s);
    if (s == m_disp[k]) return int'(SLOT_DISPLAY);
    if (s == m_rdy[k])  return int'(SLOT_READY);
    if (s == m_wr[k])   return int'(SLOT_WRITING);
    return int'(SLOT_FREE);
  endfunction

  // Model advances on the same edges the DUT does.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else for (int k = 0; k < 3; k++) model_step(k);
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic check_inst(input int k, input int wsel, input int rsel, input int stall,
                            input int rv, input int drop, input int err,
                            input int wra, input int rda);
    chk($sformatf("i%0d_write_sel", k), wsel, m_wsel[k]);
    chk($sformatf("i%0d_read_sel", k), rsel, m_disp[k]);
    chk($sformatf("i%0d_stall", k), stall, (m_wr[k] < 0) ? 1 : 0);
    chk($sformatf("i%0d_ready_valid", k), rv, (m_rdy[k] >= 0) ? 1 : 0);
    chk($sformatf("i%0d_drop_count", k), drop, m_drop[k]);
    chk($sformatf("i%0d_err", k), err, int'(m_err[k]));
    chk($sformatf("i%0d_wr_addr", k), wra, (m_wsel[k] << AB) | wa[k]);
    chk($sformatf("i%0d_rd_addr", k), rda, (m_disp[k] << AB) | ra[k]);
  endtask

  task automatic check_slots(input int k, input int st [4]);
    int nd, nw, nr;
    nd = 0; nw = 0; nr = 0;
    for (int s = 0; s < nbv[k]; s++) begin
      chk($sformatf("i%0d_slot%0d", k, s), st[s], exp_slot(k, s));
      if (st[s] == int'(SLOT_DISPLAY)) nd++;
      if (st[s] == int'(SLOT_WRITING)) nw++;
      if (st[s] == int'(SLOT_READY))   nr++;
    end
    chk($sformatf("i%0d_slot_invariant", k),
        (nd == 1 && nw <= 1 && nr <= 1) ? 1 : 0, 1);
  endtask

  // Single compare process: every negedge, all outputs and slot states.
  always @(negedge clk) begin
    int st [4];
    if (cmp_en) begin
      check_inst(0, int'(if_a.write_sel_out), int'(if_a.read_sel_out), int'(if_a.stall_out),
                 int'(if_a.ready_valid_out), int'(if_a.drop_count_out), int'(if_a.err_out),
                 int'(if_a.wr_addr_out), int'(if_a.rd_addr_out));
      check_inst(1, int'(if_b.write_sel_out), int'(if_b.read_sel_out), int'(if_b.stall_out),
                 int'(if_b.ready_valid_out), int'(if_b.drop_count_out), int'(if_b.err_out),
                 int'(if_b.wr_addr_out), int'(if_b.rd_addr_out));
      check_inst(2, int'(if_c.write_sel_out), int'(if_c.read_sel_out), int'(if_c.stall_out),
                 int'(if_c.ready_valid_out), int'(if_c.drop_count_out), int'(if_c.err_out),
                 int'(if_c.wr_addr_out), int'(if_c.rd_addr_out));
      st = '{0, 0, 0, 0};
      for (int s = 0; s < 3; s++) st[s] = int'(dut_a.slot_q[s]);
      check_slots(0, st);
      st = '{0, 0, 0, 0};
      for (int s = 0; s < 2; s++) st[s] = int'(dut_b.slot_q[s]);
      check_slots(1, st);
      st = '{0, 0, 0, 0};
      for (int s = 0; s < 4; s++) st[s] = int'(dut_c.slot_q[s]);
      check_slots(2, st);
    end
  end

  // One-cycle pulses on each instance, then settle to the next negedge.
  task automatic tick(input bit fa, input bit va, input bit fb, input bit vb,
                      input bit fc, input bit vc);
    @(posedge clk); #2;
    fd = '{fa, fb, fc};
    vs = '{va, vb, vc};
    @(posedge clk); #2;
    fd = '{0, 0, 0};
    vs = '{0, 0, 0};
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Drop reset between edges and check the outputs before the next edge.
  task automatic mid_reset();
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("rst_a_write_sel", int'(if_a.write_sel_out), 1);
    chk("rst_a_read_sel", int'(if_a.read_sel_out), 0);
    chk("rst_a_ready_valid", int'(if_a.ready_valid_out), 0);
    chk("rst_b_write_sel", int'(if_b.write_sel_out), 1);
    chk("rst_b_stall", int'(if_b.stall_out), 0);
    chk("rst_b_err", int'(if_b.err_out), 0);
    chk("rst_c_drop", int'(if_c.drop_count_out), 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    fd = '{0, 0, 0};
    vs = '{0, 0, 0};
    wa = '{5, 5, 5};
    ra = '{0, 0, 0};
    #1 rstn = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    chk("reset_a_write_sel", int'(if_a.write_sel_out), 1);
    chk("reset_a_read_sel", int'(if_a.read_sel_out), 0);
    chk("reset_a_stall", int'(if_a.stall_out), 0);
    chk("reset_a_ready_valid", int'(if_a.ready_valid_out), 0);
    chk("reset_a_drop", int'(if_a.drop_count_out), 0);
    chk("reset_a_wr_addr", int'(if_a.wr_addr_out), 'h20005);
    chk("reset_b_wr_addr", int'(if_b.wr_addr_out), 'h20005);

    // Producer finishes slot1 on both the triple and double buffer.
    tick(1, 0, 1, 0, 0, 0);
    chk("done_a_write_sel", int'(if_a.write_sel_out), 2);
    chk("done_a_ready_valid", int'(if_a.ready_valid_out), 1);
    chk("done_b_stall", int'(if_b.stall_out), 1);
    chk("model_a_write_sel", m_wsel[0], 2);

    // Done while stalled on the double buffer is an error and changes nothing.
    tick(0, 0, 1, 0, 0, 0);
    chk("stalldone_b_err", int'(if_b.err_out), 1);
    chk("stalldone_b_write_sel", int'(if_b.write_sel_out), 1);
    chk("stalldone_b_read_sel", int'(if_b.read_sel_out), 0);
    chk("stalldone_b_stall", int'(if_b.stall_out), 1);

    idle(7);
    tick(0, 1, 0, 1, 0, 0);
    chk("vsync_a_read_sel", int'(if_a.read_sel_out), 1);
    chk("vsync_a_ready_valid", int'(if_a.ready_valid_out), 0);
    chk("vsync_a_slot0_free", int'(dut_a.slot_q[0]), int'(SLOT_FREE));
    chk("vsync_b_read_sel", int'(if_b.read_sel_out), 1);
    chk("vsync_b_write_sel", int'(if_b.write_sel_out), 0);
    chk("vsync_b_stall", int'(if_b.stall_out), 0);
    chk("vsync_b_err_sticky", int'(if_b.err_out), 1);

    mid_reset();

    // Back-to-back frames with no display swap: writer goes 2,1,2.
    tick(1, 0, 0, 0, 1, 0);
    chk("burst1_a_write_sel", int'(if_a.write_sel_out), 2);
    chk("burst1_a_stall", int'(if_a.stall_out), 0);
    tick(1, 0, 0, 0, 1, 0);
    chk("burst2_a_write_sel", int'(if_a.write_sel_out), 1);
    chk("burst2_a_stall", int'(if_a.stall_out), 0);
    tick(1, 0, 0, 0, 1, 0);
    chk("burst3_a_write_sel", int'(if_a.write_sel_out), 2);
    chk("burst3_a_stall", int'(if_a.stall_out), 0);
    chk("burst3_a_drop", int'(if_a.drop_count_out), 2);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 1, 0);
    chk("sat_c_drop", int'(if_c.drop_count_out), 3);
    chk("model_c_drop", m_drop[2], 3);

    // Set up slot2 READY / slot1 WRITING, then vsync and done together.
    mid_reset();
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("pre_a_slot2_ready", int'(dut_a.slot_q[2]), int'(SLOT_READY));
    chk("pre_a_slot1_writing", int'(dut_a.slot_q[1]), int'(SLOT_WRITING));
    tick(1, 1, 0, 0, 0, 0);
    chk("same_a_read_sel", int'(if_a.read_sel_out), 2);
    chk("same_a_slot1_ready", int'(dut_a.slot_q[1]), int'(SLOT_READY));
    chk("same_a_write_sel", int'(if_a.write_sel_out), 0);
    chk("same_a_drop", int'(if_a.drop_count_out), 1);
    chk("same_a_ready_valid", int'(if_a.ready_valid_out), 1);

    // Random traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      for (int k = 0; k < 3; k++) begin
        fd[k] = ($urandom_range(0, 3) == 0);
        vs[k] = ($urandom_range(0, 4) == 0);
        wa[k] = int'($urandom_range(0, (1 << AB) - 1));
        ra[k] = int'($urandom_range(0, (1 << AB) - 1));
      end
      if ($urandom_range(0, 399) == 0) begin
        rstn = 1'b0;
        #1 rstn = 1'b1;
      end
    end
    @(posedge clk); #2;
    fd = '{0, 0, 0};
    vs = '{0, 0, 0};
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
